temporizador_mmss: RTL and testbench

- Upstream stage of the display path: generates the minutes/seconds time base that the display selector multiplexes onto the 7-segment digits.
- Operates as a stopwatch (count up) or a countdown timer (count down) from a loadable preset.
- Handles run/pause, clear and done signalling.
- Outputs Segundos/Minutos are 6-bit binary, range 0..59, and wire directly to the selector.

---
 rtl/temporizador_mmss_pkg.sv | 20 ++
 rtl/sincronizador_flanco.sv | 35 +++
 rtl/temporizador_mmss.sv | 150 +++++++++++++++
 tb/tb_temporizador_mmss.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/temporizador_mmss_pkg.sv
// Shared definitions for the mm:ss time base: state encoding, field limits
// and the default prescaler length for a 50 MHz board clock.
package temporizador_mmss_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } estado_t;

    localparam int MAX_VAL     = 59;
    localparam int DIV_DEFAULT = 50000000;

    // Clamp a 6-bit preset field into the legal 0..MAX_VAL range.
    function automatic logic [5:0] saturar(input logic [5:0] v);
        return (v > 6'(MAX_VAL)) ? 6'(MAX_VAL) : v;
    endfunction

endpackage

// File: rtl/sincronizador_flanco.sv
// Two-flop synchronizer with rising-edge detect for a raw push button.
// A button already held when reset is released is ignored until it is seen low.
module sincronizador_flanco (
    input  logic clk,
    input  logic rst,
    input  logic i_boton,
    output logic o_pulso
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_vld;
    logic r_armado;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_prev   <= 1'b0;
            r_vld    <= 1'b0;
            r_armado <= 1'b0;
        end else begin
            r_meta   <= i_boton;
            r_sync   <= r_meta;
            r_prev   <= r_sync;
            r_vld    <= 1'b1;
            // Arm only after a genuine post-reset low sample has been taken.
            r_armado <= r_armado | (r_vld & ~r_meta);
        end
    end

    assign o_pulso = r_sync & ~r_prev & r_armado;

endmodule

// File: rtl/temporizador_mmss.sv
// Minutes/seconds stopwatch and countdown timer feeding the 7-segment selector.
// Run/pause and clear come from raw buttons; carga loads a saturated preset.
module temporizador_mmss
    import temporizador_mmss_pkg::*;
#(
    parameter int DIV = DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       modo,
    input  logic       carga,
    input  logic [5:0] preset_min,
    input  logic [5:0] preset_seg,
    output logic [5:0] Segundos,
    output logic [5:0] Minutos,
    output logic       corriendo,
    output logic       fin,
    output logic       tick_1hz,
    output estado_t    o_estado
);

    localparam int              PW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]   PRESC_FIN = PW'(DIV - 1);

    logic          w_start;
    logic          w_clear;
    estado_t       r_estado;
    estado_t       w_estado_sig;
    logic [PW-1:0] r_presc;
    logic [PW-1:0] w_presc_sig;
    logic [5:0]    r_seg;
    logic [5:0]    r_min;
    logic [5:0]    w_seg_sig;
    logic [5:0]    w_min_sig;
    logic          w_tick;
    logic          w_tick_apl;
    logic          w_carga_ok;
    logic          w_cero;
    logic          r_tick;
    logic          r_corriendo;
    logic          r_fin;

    sincronizador_flanco u_sinc_start (
        .clk     (clk),
        .rst     (rst),
        .i_boton (btn_start),
        .o_pulso (w_start)
    );

    sincronizador_flanco u_sinc_clear (
        .clk     (clk),
        .rst     (rst),
        .i_boton (btn_clear),
        .o_pulso (w_clear)
    );

    assign w_tick     = (r_estado == ST_RUN) && (r_presc == PRESC_FIN);
    assign w_carga_ok = carga && ((r_estado == ST_IDLE) || (r_estado == ST_PAUSE));
    assign w_cero     = (r_seg == 6'd0) && (r_min == 6'd0);

    always_comb begin
        w_estado_sig = r_estado;
        w_presc_sig  = r_presc;
        w_seg_sig    = r_seg;
        w_min_sig    = r_min;
        w_tick_apl   = 1'b0;

        if (w_clear) begin
            w_estado_sig = ST_IDLE;
            w_presc_sig  = '0;
            w_seg_sig    = 6'd0;
            w_min_sig    = 6'd0;
        end else if (w_carga_ok) begin
            // An accepted load swallows any start pulse in the same cycle.
            w_seg_sig   = saturar(preset_seg);
            w_min_sig   = saturar(preset_min);
            w_presc_sig = '0;
        end else begin
            if (r_estado == ST_RUN) begin
                w_presc_sig = w_tick ? '0 : r_presc + 1'b1;
            end

            if (w_tick) begin
                w_tick_apl = 1'b1;
                if (!modo) begin
                    if (r_seg == 6'(MAX_VAL)) begin
                        w_seg_sig = 6'd0;
                        w_min_sig = (r_min == 6'(MAX_VAL)) ? 6'd0 : r_min + 6'd1;
                    end else begin
                        w_seg_sig = r_seg + 6'd1;
                    end
                end else if (w_cero) begin
                    w_estado_sig = ST_DONE;
                end else begin
                    if (r_seg == 6'd0) begin
                        w_seg_sig = 6'(MAX_VAL);
                        w_min_sig = r_min - 6'd1;
                    end else begin
                        w_seg_sig = r_seg - 6'd1;
                    end
                    if ((r_min == 6'd0) && (r_seg == 6'd1)) begin
                        w_estado_sig = ST_DONE;
                    end
                end
            end

            if (w_start) begin
                case (r_estado)
                    ST_IDLE:  if (!(modo && w_cero)) w_estado_sig = ST_RUN;
                    ST_RUN:   if (w_estado_sig != ST_DONE) w_estado_sig = ST_PAUSE;
                    ST_PAUSE: w_estado_sig = ST_RUN;
                    ST_DONE: begin
                        w_estado_sig = ST_IDLE;
                        w_presc_sig  = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_estado    <= ST_IDLE;
            r_presc     <= '0;
            r_seg       <= 6'd0;
            r_min       <= 6'd0;
            r_tick      <= 1'b0;
            r_corriendo <= 1'b0;
            r_fin       <= 1'b0;
        end else begin
            r_estado    <= w_estado_sig;
            r_presc     <= w_presc_sig;
            r_seg       <= w_seg_sig;
            r_min       <= w_min_sig;
            r_tick      <= w_tick_apl;
            r_corriendo <= (w_estado_sig == ST_RUN);
            r_fin       <= (w_estado_sig == ST_DONE);
        end
    end

    assign Segundos  = r_seg;
    assign Minutos   = r_min;
    assign tick_1hz  = r_tick;
    assign corriendo = r_corriendo;
    assign fin       = r_fin;
    assign o_estado  = r_estado;

endmodule

// File: tb/tb_temporizador_mmss.sv
// Bench for temporizador_mmss: a seconds-total reference model checked every
// cycle, plus directed scenarios with hand-derived literal expectations.
module tb_temporizador_mmss;
    import temporizador_mmss_pkg::*;

    localparam int DIV = 4;

    logic       clk        = 1'b0;
    logic       rst        = 1'b1;
    logic       btn_start  = 1'b0;
    logic       btn_clear  = 1'b0;
    logic       modo       = 1'b0;
    logic       carga      = 1'b0;
    logic [5:0] preset_min = 6'd0;
    logic [5:0] preset_seg = 6'd0;
    logic [5:0] Segundos;
    logic [5:0] Minutos;
    logic       corriendo;
    logic       fin;
    logic       tick_1hz;
    estado_t    dut_estado;

    temporizador_mmss #(.DIV(DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_start  (btn_start),
        .btn_clear  (btn_clear),
        .modo       (modo),
        .carga      (carga),
        .preset_min (preset_min),
        .preset_seg (preset_seg),
        .Segundos   (Segundos),
        .Minutos    (Minutos),
        .corriendo  (corriendo),
        .fin        (fin),
        .tick_1hz   (tick_1hz),
        .o_estado   (dut_estado)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: time kept as total seconds; states 0 idle, 1 run, 2 pause, 3 done.
    int m_state = 0;
    int m_secs  = 0;
    int m_presc = 0;
    int m_tick  = 0;
    bit q_start[$];
    bit q_clear[$];
    bit ps_m, pc_m, tk_m, load_ok_m;
    int prev_m;

    // A press counts on the clock where the post-reset sample from two clocks
    // back is high and the one from three clocks back is low.
    function automatic bit flanco(input bit q[$]);
        int n = q.size();
        return (n >= 3) && q[n-2] && !q[n-3];
    endfunction

    function automatic int sat6(input int v);
        return (v > 59) ? 59 : v;
    endfunction

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_state = 0; m_secs = 0; m_presc = 0; m_tick = 0;
            q_start.delete();
            q_clear.delete();
        end else begin
            ps_m = flanco(q_start);
            pc_m = flanco(q_clear);
            q_start.push_back(btn_start);
            q_clear.push_back(btn_clear);
            if (q_start.size() > 3) void'(q_start.pop_front());
            if (q_clear.size() > 3) void'(q_clear.pop_front());
            m_tick    = 0;
            load_ok_m = carga && (m_state == 0 || m_state == 2);
            if (pc_m) begin
                m_state = 0; m_secs = 0; m_presc = 0;
            end else if (load_ok_m) begin
                m_secs  = sat6(int'(preset_min)) * 60 + sat6(int'(preset_seg));
                m_presc = 0;
            end else begin
                prev_m = m_state;
                tk_m   = (m_state == 1) && (m_presc == DIV - 1);
                if (m_state == 1) m_presc = (m_presc + 1) % DIV;
                if (tk_m) begin
                    m_tick = 1;
                    if (!modo) m_secs = (m_secs + 1) % 3600;
                    else if (m_secs == 0) m_state = 3;
                    else begin
                        m_secs = m_secs - 1;
                        if (m_secs == 0) m_state = 3;
                    end
                end
                if (ps_m) begin
                    case (prev_m)
                        0: if (!(modo && m_secs == 0)) m_state = 1;
                        1: if (m_state != 3) m_state = 2;
                        2: m_state = 1;
                        default: begin m_state = 0; m_presc = 0; end
                    endcase
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (!rst) begin
            chk("model_seg",       Segundos,       m_secs % 60);
            chk("model_min",       Minutos,        m_secs / 60);
            chk("model_corriendo", corriendo,      int'(m_state == 1));
            chk("model_fin",       fin,            int'(m_state == 3));
            chk("model_tick",      tick_1hz,       m_tick);
            chk("model_estado",    int'(dut_estado), m_state);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_start();
        btn_start = 1'b1; cyc(4); btn_start = 1'b0; cyc(1);
    endtask

    task automatic press_clear();
        btn_clear = 1'b1; cyc(4); btn_clear = 1'b0; cyc(1);
    endtask

    task automatic load(input int mm, input int ss);
        preset_min = 6'(mm); preset_seg = 6'(ss); carga = 1'b1; cyc(1); carga = 1'b0;
    endtask

    task automatic wait_tick(input string name, output int waited);
        bit got = 0;
        waited = 0;
        for (int i = 0; i < 4 * DIV && !got; i++) begin
            @(negedge clk);
            got    = tick_1hz;
            waited = i + 1;
        end
        chk(name, int'(got), 1);
    endtask

    initial begin
        int nt;
        int w;
        cyc(2);
        rst = 1'b0;
        chk("rst_seg", Segundos, 0);
        chk("rst_min", Minutos, 0);
        chk("rst_corriendo", corriendo, 0);
        chk("rst_fin", fin, 0);
        nt = 0;
        repeat (10 * DIV) begin @(negedge clk); nt += int'(tick_1hz); end
        chk("idle_no_tick", nt, 0);

        // Stopwatch wrap through 59:59
        modo = 1'b0;
        load(59, 58);
        chk("wrap_load_min", Minutos, 59);
        chk("wrap_load_seg", Segundos, 58);
        press_start();
        wait_tick("wrap_t1", w);
        chk("wrap_5959_min", Minutos, 59);
        chk("wrap_5959_seg", Segundos, 59);
        wait_tick("wrap_t2", w);
        chk("wrap_0000_min", Minutos, 0);
        chk("wrap_0000_seg", Segundos, 0);
        chk("wrap_corriendo", corriendo, 1);
        wait_tick("wrap_t3", w);
        chk("wrap_0001_seg", Segundos, 1);
        press_clear();
        chk("clr_run_seg", Segundos, 0);
        chk("clr_run_estado", int'(dut_estado), 0);

        // Countdown 01:00 to done
        modo = 1'b1;
        load(1, 0);
        press_start();
        wait_tick("down_t1", w);
        chk("down_first_min", Minutos, 0);
        chk("down_first_seg", Segundos, 59);
        for (int k = 0; k < 59; k++) wait_tick("down_tk", w);
        chk("done_seg", Segundos, 0);
        chk("done_min", Minutos, 0);
        chk("done_fin", fin, 1);
        chk("done_corriendo", corriendo, 0);
        cyc(20);
        chk("done_hold_seg", Segundos, 0);
        chk("done_hold_fin", fin, 1);
        press_start();
        chk("done_to_idle_fin", fin, 0);
        chk("done_to_idle_estado", int'(dut_estado), 0);
        press_start();
        chk("down_zero_stays_idle", int'(dut_estado), 0);

        // Pause and resume
        modo = 1'b0;
        load(0, 10);
        press_start();
        wait_tick("pause_t1", w);
        chk("pause_before_seg", Segundos, 11);
        press_start();
        cyc(20);
        chk("pause_frozen_seg", Segundos, 11);
        chk("pause_estado", int'(dut_estado), 2);
        chk("pause_corriendo", corriendo, 0);
        btn_start = 1'b1;
        wait_tick("resume_tick", w);
        chk("resume_latency", w, 4);
        chk("resume_seg", Segundos, 12);
        btn_start = 1'b0;
        cyc(2);
        press_clear();

        // carga and start landing on the same clock; saturated preset
        btn_start = 1'b1;
        cyc(2);
        preset_min = 6'd63; preset_seg = 6'd40; carga = 1'b1;
        cyc(1);
        carga = 1'b0;
        chk("prio_min_sat", Minutos, 59);
        chk("prio_seg", Segundos, 40);
        chk("prio_estado_idle", int'(dut_estado), 0);
        cyc(2);
        btn_start = 1'b0;
        cyc(2);
        press_start();
        cyc(2);
        load(5, 5);
        chk("carga_run_ignored_min", Minutos, 59);
        chk("carga_run_estado", int'(dut_estado), 1);
        press_clear();
        chk("clr2_min", Minutos, 0);
        chk("clr2_estado", int'(dut_estado), 0);

        // Asynchronous reset in the middle of a run
        press_start();
        wait_tick("arst_t1", w);
        wait_tick("arst_t2", w);
        btn_start = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("arst_seg", Segundos, 0);
        chk("arst_min", Minutos, 0);
        chk("arst_corriendo", corriendo, 0);
        chk("arst_tick", tick_1hz, 0);
        chk("arst_estado", int'(dut_estado), 0);
        cyc(2);
        rst = 1'b0;
        cyc(12);
        chk("arst_held_no_pulse", int'(dut_estado), 0);
        chk("arst_held_corriendo", corriendo, 0);
        btn_start = 1'b0;
        cyc(3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule
